// File: rtl/cpu_pkg.sv
// Shared encodings, FSM/ALU enums and decode helpers for the multicycle RV64I-subset core.
package cpu_pkg;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_ADDI   = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    localparam logic [2:0]  F3_ADD    = 3'b000;
    localparam logic [2:0]  F3_AND    = 3'b111;
    localparam logic [2:0]  F3_OR     = 3'b110;
    localparam logic [2:0]  F3_D      = 3'b011;
    localparam logic [2:0]  F3_BEQ    = 3'b000;

    localparam logic [6:0]  F7_ADD    = 7'b0000000;
    localparam logic [6:0]  F7_SUB    = 7'b0100000;

    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        INS_R       = 3'd0,
        INS_ADDI    = 3'd1,
        INS_LD      = 3'd2,
        INS_SD      = 3'd3,
        INS_BEQ     = 3'd4,
        INS_EBREAK  = 3'd5,
        INS_ILLEGAL = 3'd6
    } ins_e;

    function automatic ins_e classify(input logic [31:0] ir);
        ins_e       k;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ir[14:12];
        f7 = ir[31:25];
        k  = INS_ILLEGAL;
        if (ir == EBREAK) begin
            k = INS_EBREAK;
        end else begin
            case (ir[6:0])
                OP_R: begin
                    if (f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) begin
                        k = INS_R;
                    end else if ((f3 == F3_AND || f3 == F3_OR) && f7 == F7_ADD) begin
                        k = INS_R;
                    end else begin
                        k = INS_ILLEGAL;
                    end
                end
                OP_ADDI:   k = (f3 == F3_ADD) ? INS_ADDI : INS_ILLEGAL;
                OP_LOAD:   k = (f3 == F3_D)   ? INS_LD   : INS_ILLEGAL;
                OP_STORE:  k = (f3 == F3_D)   ? INS_SD   : INS_ILLEGAL;
                OP_BRANCH: k = (f3 == F3_BEQ) ? INS_BEQ  : INS_ILLEGAL;
                default:   k = INS_ILLEGAL;
            endcase
        end
        return k;
    endfunction

    // Everything except R-type and/or/sub adds (addi, address calc, branch target).
    function automatic alu_op_e alu_op_of(input logic [31:0] ir);
        alu_op_e op;
        op = ALU_ADD;
        if (ir[6:0] == OP_R) begin
            case (ir[14:12])
                F3_AND:  op = ALU_AND;
                F3_OR:   op = ALU_OR;
                default: op = ir[30] ? ALU_SUB : ALU_ADD;
            endcase
        end else begin
            op = ALU_ADD;
        end
        return op;
    endfunction

    function automatic logic [31:0] imm32_of(input logic [31:0] ir);
        logic [31:0] imm;
        case (ir[6:0])
            OP_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:   imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous write port,
// x0 reads as zero and ignores writes, whole array cleared by the synchronous reset.
module mc_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] raddr1,
    input  logic [$clog2(NREGS)-1:0] raddr2,
    output logic [XLEN-1:0]          rdata1,
    output logic [XLEN-1:0]          rdata2,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata
);

    localparam int RW = $clog2(NREGS);

    logic [XLEN-1:0] regs_r [NREGS];

    // Register array: clear on reset, single write port elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (waddr != {RW{1'b0}})) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == {RW{1'b0}}) ? {XLEN{1'b0}} : regs_r[raddr1];
    assign rdata2 = (raddr2 == {RW{1'b0}}) ? {XLEN{1'b0}} : regs_r[raddr2];

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multicycle RV64I-subset core: one FSM walks FETCH/DECODE/EXEC/MEM/WB around a shared ALU,
// with handshaked external instruction and data memories.
module multicycle_cpu_core
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic [XLEN-1:0] pc_out,
    output logic            halted,
    output logic            illegal
);

    localparam int RW = $clog2(NREGS);

    state_e          state_r, state_s;
    ins_e            kind_r, kind_s;
    alu_op_e         aluop_r, aluop_s;
    logic [XLEN-1:0] pc_r, a_r, b_r, imm_r, aluout_r, mdr_r;
    logic [31:0]     ir_r;
    logic            halted_r, illegal_r;

    logic [XLEN-1:0] imm_s, pc_plus4_s, alu_a_s, alu_b_s, alu_y_s;
    logic [XLEN-1:0] rf_rd1_s, rf_rd2_s, rf_wdata_s;
    logic            rf_we_s;

    assign kind_s     = classify(ir_r);
    assign aluop_s    = alu_op_of(ir_r);
    assign imm_s      = XLEN'($signed(imm32_of(ir_r)));
    assign pc_plus4_s = pc_r + XLEN'(3'd4);
    assign rf_we_s    = (state_r == ST_WB);
    assign rf_wdata_s = (kind_r == INS_LD) ? mdr_r : aluout_r;

    mc_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (RW'(ir_r[19:15])),
        .raddr2 (RW'(ir_r[24:20])),
        .rdata1 (rf_rd1_s),
        .rdata2 (rf_rd2_s),
        .we     (rf_we_s),
        .waddr  (RW'(ir_r[11:7])),
        .wdata  (rf_wdata_s)
    );

    // Shared ALU: branches feed pc as operand A, R-type uses B, everything else the immediate.
    always_comb begin
        alu_a_s = a_r;
        alu_b_s = imm_r;
        alu_y_s = {XLEN{1'b0}};
        if (kind_r == INS_BEQ) begin
            alu_a_s = pc_r;
        end else begin
            alu_a_s = a_r;
        end
        if (kind_r == INS_R) begin
            alu_b_s = b_r;
        end else begin
            alu_b_s = imm_r;
        end
        case (aluop_r)
            ALU_ADD: alu_y_s = alu_a_s + alu_b_s;
            ALU_SUB: alu_y_s = alu_a_s - alu_b_s;
            ALU_AND: alu_y_s = alu_a_s & alu_b_s;
            ALU_OR:  alu_y_s = alu_a_s | alu_b_s;
            default: alu_y_s = alu_a_s + alu_b_s;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FETCH:  state_s = imem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (kind_s == INS_ILLEGAL || kind_s == INS_EBREAK) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (kind_r)
                    INS_R, INS_ADDI: state_s = ST_WB;
                    INS_LD, INS_SD:  state_s = ST_MEM;
                    INS_BEQ:         state_s = ST_FETCH;
                    default:         state_s = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_s = (kind_r == INS_SD) ? ST_FETCH : ST_WB;
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_WB:   state_s = ST_FETCH;
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_HALT;
        endcase
    end

    // Datapath registers: IR, operands, ALU result, load data, pc and sticky halt flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r      <= RESET_PC;
            ir_r      <= 32'h0000_0000;
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            imm_r     <= {XLEN{1'b0}};
            aluout_r  <= {XLEN{1'b0}};
            mdr_r     <= {XLEN{1'b0}};
            kind_r    <= INS_R;
            aluop_r   <= ALU_ADD;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir_r <= imem_rdata;
                    end
                end
                ST_DECODE: begin
                    a_r     <= rf_rd1_s;
                    b_r     <= rf_rd2_s;
                    imm_r   <= imm_s;
                    kind_r  <= kind_s;
                    aluop_r <= aluop_s;
                    if (kind_s == INS_ILLEGAL) begin
                        halted_r  <= 1'b1;
                        illegal_r <= 1'b1;
                    end else if (kind_s == INS_EBREAK) begin
                        halted_r  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    aluout_r <= alu_y_s;
                    if (kind_r == INS_BEQ) begin
                        pc_r <= (a_r == b_r) ? alu_y_s : pc_plus4_s;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (kind_r == INS_SD) begin
                            pc_r <= pc_plus4_s;
                        end else begin
                            mdr_r <= dmem_rdata;
                        end
                    end
                end
                ST_WB:   pc_r <= pc_plus4_s;
                default: pc_r <= pc_r;
            endcase
        end
    end

    // FSM outputs; everything is forced low while reset is held so an in-flight access is dropped.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = {XLEN{1'b0}};
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = {XLEN{1'b0}};
        dmem_wdata = {XLEN{1'b0}};
        retire     = 1'b0;
        pc_out     = {XLEN{1'b0}};
        halted     = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            imem_addr  = pc_r;
            dmem_addr  = aluout_r;
            dmem_wdata = b_r;
            pc_out     = pc_r;
            halted     = halted_r;
            illegal    = illegal_r;
            case (state_r)
                ST_FETCH: imem_req = 1'b1;
                ST_EXEC:  retire   = (kind_r == INS_BEQ);
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (kind_r == INS_SD);
                    retire   = dmem_ready && (kind_r == INS_SD);
                end
                ST_WB:    retire   = 1'b1;
                default:  retire   = 1'b0;
            endcase
        end else begin
            retire = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Self-checking bench for multicycle_cpu_core: small programs, wait-state memory models,
// and scoreboards of expected retires (pc, latency) and stores (address, data).
module tb_multicycle_cpu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ready;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        retire, halted, illegal;
    logic [63:0] pc_out;

    multicycle_cpu_core dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .retire     (retire),
        .pc_out     (pc_out),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; int lat; } ret_t;
    typedef struct { logic [63:0] addr; logic [63:0] data; } st_t;

    ret_t        exp_ret_q[$];
    st_t         exp_st_q[$];
    logic [31:0] imem [64];
    logic [63:0] dmem [64];
    int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    bit          i_busy = 1'b0, d_busy = 1'b0;
    logic [63:0] i_addr0, d_addr0;
    int          cyc = 0, last_ret = 0;
    int          n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_sd(input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], rs2, rs1, 3'b011, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2, input int imm);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return enc_i(7'b0010011, rd, 3'b000, rs1, imm);
    endfunction

    function automatic logic [31:0] ld(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return enc_i(7'b0000011, rd, 3'b011, rs1, imm);
    endfunction

    task automatic put(input int addr, input logic [31:0] w);
        imem[addr/4] = w;
    endtask

    task automatic exp_ret(input logic [63:0] pc, input int lat);
        ret_t e;
        e.pc = pc; e.lat = lat;
        exp_ret_q.push_back(e);
    endtask

    task automatic exp_st(input logic [63:0] addr, input logic [63:0] data);
        st_t s;
        s.addr = addr; s.data = data;
        exp_st_q.push_back(s);
    endtask

    always @(posedge clk) cyc++;

    // Instruction memory: iwait wait states per fetch, spurious ready/garbage while idle.
    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            if (!i_busy) begin
                i_busy  = 1'b1;
                i_addr0 = imem_addr;
            end
            if (icnt >= iwait) begin
                if (iwait > 0) check_eq("imem_addr_stable", imem_addr, i_addr0);
                imem_ready = 1'b1;
                imem_rdata = imem[imem_addr[7:2]];
                icnt = 0;
                i_busy = 1'b0;
            end else begin
                imem_ready = 1'b0;
                imem_rdata = 32'hFFFF_FFFF;
                icnt++;
            end
        end else begin
            imem_ready = 1'b1;
            imem_rdata = 32'hFFFF_FFFF;
            icnt = 0;
            i_busy = 1'b0;
        end
    end

    // Data memory: dwait wait states per access; accepted stores are checked against the scoreboard.
    always @(negedge clk) begin
        st_t s;
        if (dmem_req === 1'b1) begin
            if (!d_busy) begin
                d_busy  = 1'b1;
                d_addr0 = dmem_addr;
            end
            if (dcnt >= dwait) begin
                if (dwait > 0) check_eq("dmem_addr_stable", dmem_addr, d_addr0);
                dmem_ready = 1'b1;
                if (dmem_we === 1'b1) begin
                    check_eq("store_expected", 64'(exp_st_q.size() != 0), 64'(1));
                    if (exp_st_q.size() != 0) begin
                        s = exp_st_q.pop_front();
                        check_eq("store_addr", dmem_addr, s.addr);
                        check_eq("store_data", dmem_wdata, s.data);
                    end
                    dmem[dmem_addr[8:3]] = dmem_wdata;
                    dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                end else begin
                    dmem_rdata = dmem[dmem_addr[8:3]];
                end
                dcnt = 0;
                d_busy = 1'b0;
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                dcnt++;
            end
        end else begin
            dmem_ready = 1'b1;
            dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            dcnt = 0;
            d_busy = 1'b0;
        end
    end

    // Retire monitor: pc and cycles since the previous retire (or reset release).
    always begin
        ret_t e;
        @(negedge clk);
        #1;
        if (retire === 1'b1) begin
            check_eq("retire_expected", 64'(exp_ret_q.size() != 0), 64'(1));
            if (exp_ret_q.size() != 0) begin
                e = exp_ret_q.pop_front();
                check_eq("retire_pc", pc_out, e.pc);
                check_eq("retire_lat", 64'(cyc - last_ret), 64'(e.lat));
            end
            last_ret = cyc;
        end
    end

    task automatic assert_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("rst_gate", {61'd0, imem_req, dmem_req, retire}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_pc", pc_out, 64'd0);
        check_eq("rst_flags", {62'd0, halted, illegal}, 64'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        last_ret = cyc - 1;
        #1;
        check_eq("restart_req", 64'(imem_req), 64'd1);
        check_eq("restart_addr", imem_addr, 64'd0);
    endtask

    task automatic new_prog(input int iw, input int dw);
        for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF;
        iwait = iw;
        dwait = dw;
    endtask

    task automatic finish_prog(input string tag, input logic exp_illegal);
        int n = 0;
        while (halted !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #2;
        check_eq({tag, "_halted"}, 64'(halted), 64'd1);
        check_eq({tag, "_illegal"}, 64'(illegal), 64'(exp_illegal));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check_eq({tag, "_halt_noreq"}, {62'd0, imem_req, retire}, 64'd0);
        end
        check_eq({tag, "_retires_left"}, 64'(exp_ret_q.size()), 64'd0);
        check_eq({tag, "_stores_left"}, 64'(exp_st_q.size()), 64'd0);
        exp_ret_q.delete();
        exp_st_q.delete();
    endtask

    initial begin
        logic [31:0] bad [3];
        int n;
        for (int i = 0; i < 64; i++) dmem[i] = 64'd0;

        // Program 1: addi/addi/add, result stored.
        new_prog(0, 0);
        put(32'h00, addi(5'd1, 5'd0, 5));
        put(32'h04, addi(5'd2, 5'd0, -3));
        put(32'h08, enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3));
        put(32'h0C, enc_sd(5'd3, 5'd0, 0));
        put(32'h10, 32'h0010_0073);
        exp_ret(64'h00, 4); exp_ret(64'h04, 4); exp_ret(64'h08, 4); exp_ret(64'h0C, 4);
        exp_st(64'd0, 64'd2);
        assert_reset();
        release_reset();
        finish_prog("p1", 1'b0);

        // Program 2: sub/and/or, x0 write, taken/not-taken/backward beq.
        new_prog(0, 0);
        put(32'h00, addi(5'd1, 5'd0, 32'hF0));
        put(32'h04, addi(5'd2, 5'd0, 32'h3C));
        put(32'h08, enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3));
        put(32'h0C, enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd4));
        put(32'h10, enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd5));
        put(32'h14, enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0));
        put(32'h18, enc_sd(5'd3, 5'd0, 0));
        put(32'h1C, enc_sd(5'd4, 5'd0, 8));
        put(32'h20, enc_sd(5'd5, 5'd0, 16));
        put(32'h24, enc_sd(5'd0, 5'd0, 24));
        put(32'h28, enc_beq(5'd1, 5'd1, 8));
        put(32'h30, enc_beq(5'd1, 5'd2, 8));
        put(32'h34, enc_beq(5'd1, 5'd1, 12));
        put(32'h38, enc_sd(5'd1, 5'd0, 32));
        put(32'h3C, 32'h0010_0073);
        put(32'h40, enc_beq(5'd0, 5'd0, -8));
        for (int i = 0; i < 10; i++) exp_ret(64'(4 * i), 4);
        exp_ret(64'h28, 3); exp_ret(64'h30, 3); exp_ret(64'h34, 3); exp_ret(64'h40, 3);
        exp_ret(64'h38, 4);
        exp_st(64'd0, 64'hB4); exp_st(64'd8, 64'h30); exp_st(64'd16, 64'hFC);
        exp_st(64'd24, 64'd0); exp_st(64'd32, 64'hF0);
        assert_reset();
        release_reset();
        finish_prog("p2", 1'b0);

        // Program 3: store/load round trip with 3 data wait states.
        new_prog(0, 3);
        put(32'h00, addi(5'd1, 5'd0, 8));
        put(32'h04, addi(5'd3, 5'd0, -1));
        put(32'h08, enc_sd(5'd3, 5'd0, 8));
        put(32'h0C, ld(5'd4, 5'd0, 8));
        put(32'h10, enc_sd(5'd4, 5'd1, 8));
        put(32'h14, addi(5'd5, 5'd4, 2));
        put(32'h18, enc_sd(5'd5, 5'd1, 0));
        put(32'h1C, 32'h0010_0073);
        exp_ret(64'h00, 4); exp_ret(64'h04, 4); exp_ret(64'h08, 7); exp_ret(64'h0C, 8);
        exp_ret(64'h10, 7); exp_ret(64'h14, 4); exp_ret(64'h18, 7);
        exp_st(64'd8, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_st(64'd16, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_st(64'd8, 64'd1);
        assert_reset();
        release_reset();
        finish_prog("p3", 1'b0);

        // Program 4: instruction wait states plus a data wait state.
        new_prog(2, 1);
        put(32'h00, addi(5'd1, 5'd0, 7));
        put(32'h04, enc_sd(5'd1, 5'd0, 0));
        put(32'h08, 32'h0010_0073);
        exp_ret(64'h00, 6); exp_ret(64'h04, 7);
        exp_st(64'd0, 64'd7);
        assert_reset();
        release_reset();
        finish_prog("p4", 1'b0);

        // Programs 5a-c: unsupported encodings trap without retiring.
        bad[0] = 32'hFFFF_FFFF;
        bad[1] = enc_i(7'b0000011, 5'd1, 3'b010, 5'd0, 0);
        bad[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd3);
        for (int k = 0; k < 3; k++) begin
            new_prog(0, 0);
            put(32'h00, addi(5'd1, 5'd0, 1));
            put(32'h04, bad[k]);
            exp_ret(64'h00, 4);
            assert_reset();
            release_reset();
            finish_prog("p5", 1'b1);
        end

        // Program 6: reset during the data wait of a load aborts it without writeback.
        new_prog(0, 30);
        dmem[0] = 64'h55;
        put(32'h00, enc_sd(5'd4, 5'd0, 8));
        put(32'h04, ld(5'd4, 5'd0, 0));
        put(32'h08, enc_sd(5'd4, 5'd0, 8));
        put(32'h0C, 32'h0010_0073);
        exp_ret(64'h00, 34);
        exp_st(64'd8, 64'd0);
        assert_reset();
        release_reset();
        n = 0;
        while (exp_ret_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("p6_first_retire", 64'(exp_ret_q.size()), 64'd0);
        n = 0;
        while (dmem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("p6_ld_req", 64'(dmem_req), 64'd1);
        check_eq("p6_ld_we", 64'(dmem_we), 64'd0);
        repeat (2) @(negedge clk);
        assert_reset();
        dwait = 0;
        exp_ret(64'h00, 4); exp_ret(64'h04, 5); exp_ret(64'h08, 4);
        exp_st(64'd8, 64'd0); exp_st(64'd8, 64'h55);
        release_reset();
        finish_prog("p6", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
